// File: rtl/phase_countdown_timer.sv
// ---------------------------------------------------------------------------
// phase_countdown_timer
//
// Programmable seconds countdown timer for the traffic-light phase FSM.
// A prescaler divides clk down to one-second "second edges". The seconds
// counter (remaining) is loaded from dur_sec on start. It is decremented on
// each second edge, and it expires on the second edge where it holds 1.
// In periodic mode it reloads the latched duration on that same edge, so
// there is no dead cycle between periods.
//
// Parameters
//   CLK_FREQ   clk cycles per second (>= 1)
//   SEC_W      width of the duration / remaining fields in seconds
//
// Ports
//   clk        in   1      system clock
//   rst        in   1      synchronous, active-high reset
//   start      in   1      load dur_sec / periodic and begin counting
//   dur_sec    in   SEC_W  duration in seconds, sampled with start
//   periodic   in   1      sampled with start: 1 = auto-reload on expiry
//   pause      in   1      level: freeze prescaler and remaining
//   abort      in   1      cancel the count without a done pulse
//   busy       out  1      1 while counting or paused
//   done       out  1      one-cycle pulse on expiry
//   tick       out  1      one-cycle pulse at each elapsed second
//   remaining  out  SEC_W  whole seconds left, 0 when idle
//
// Per-edge priority: rst > abort > start > pause > count.
// All outputs are registered.
// ---------------------------------------------------------------------------
module phase_countdown_timer #(
  parameter int CLK_FREQ = 10,
  parameter int SEC_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEC_W-1:0] dur_sec,
  input  logic             periodic,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             tick,
  output logic [SEC_W-1:0] remaining
);

  // A CLK_FREQ of 1 still gets a 1-bit prescaler. The prescaler then sits at
  // 0, so every counting edge is a second edge.
  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;

  localparam logic [PW-1:0]    PRESC_LAST = PW'(CLK_FREQ - 1);
  localparam logic [PW-1:0]    PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]    PRESC_ONE  = PW'(1'b1);
  localparam logic [SEC_W-1:0] SEC_ZERO   = {SEC_W{1'b0}};
  localparam logic [SEC_W-1:0] SEC_ONE    = SEC_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_s;
  logic [PW-1:0]    presc_r;
  logic [PW-1:0]    presc_s;
  logic [SEC_W-1:0] dur_r;
  logic [SEC_W-1:0] dur_s;
  logic             periodic_r;
  logic             periodic_s;
  logic [SEC_W-1:0] remaining_s;
  logic             busy_s;
  logic             done_s;
  logic             tick_s;

  // Next-state and next-output logic for the whole timer.
  always_comb begin
    state_s     = state_r;
    presc_s     = presc_r;
    dur_s       = dur_r;
    periodic_s  = periodic_r;
    remaining_s = remaining;
    done_s      = 1'b0;
    tick_s      = 1'b0;

    if (abort) begin
      // A cancelled count never reports completion, even on its expiry edge.
      state_s     = ST_IDLE;
      presc_s     = PRESC_ZERO;
      remaining_s = SEC_ZERO;
    end else if (start) begin
      presc_s = PRESC_ZERO;
      if (dur_sec == SEC_ZERO) begin
        // A zero-length request completes immediately and never reloads.
        state_s     = ST_IDLE;
        remaining_s = SEC_ZERO;
        done_s      = 1'b1;
      end else begin
        remaining_s = dur_sec;
        dur_s       = dur_sec;
        periodic_s  = periodic;
        if (pause) begin
          state_s = ST_PAUSED;
        end else begin
          state_s = ST_RUN;
        end
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_RUN, ST_PAUSED: begin
          if (pause) begin
            // Hold everything. tick stays at its default of 0.
            state_s = ST_PAUSED;
          end else begin
            // When leaving PAUSED, counting resumes on this same edge.
            state_s = ST_RUN;
            if (presc_r == PRESC_LAST) begin
              presc_s = PRESC_ZERO;
              tick_s  = 1'b1;
              if (remaining == SEC_ONE) begin
                done_s = 1'b1;
                if (periodic_r) begin
                  remaining_s = dur_r;
                end else begin
                  state_s     = ST_IDLE;
                  remaining_s = SEC_ZERO;
                end
              end else begin
                remaining_s = remaining - SEC_ONE;
              end
            end else begin
              presc_s = presc_r + PRESC_ONE;
            end
          end
        end
        default: begin
          state_s     = ST_IDLE;
          presc_s     = PRESC_ZERO;
          remaining_s = SEC_ZERO;
        end
      endcase
    end

    busy_s = (state_s != ST_IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      presc_r    <= PRESC_ZERO;
      dur_r      <= SEC_ZERO;
      periodic_r <= 1'b0;
      remaining  <= SEC_ZERO;
      busy       <= 1'b0;
      done       <= 1'b0;
      tick       <= 1'b0;
    end else begin
      state_r    <= state_s;
      presc_r    <= presc_s;
      dur_r      <= dur_s;
      periodic_r <= periodic_s;
      remaining  <= remaining_s;
      busy       <= busy_s;
      done       <= done_s;
      tick       <= tick_s;
    end
  end

endmodule

// File: tb/tb_phase_countdown_timer.sv
// Bench for phase_countdown_timer. Two instances (CLK_FREQ=10 and CLK_FREQ=1)
// share one stimulus stream. Each instance is checked every cycle against an
// elapsed-cycle reference model (remaining = D - elapsed/F), and directed
// latency and count checks are done on top of that.
module tb_phase_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dur_sec;
  logic       periodic;
  logic       pause;
  logic       abort;

  logic       busy_a, done_a, tick_a;
  logic [7:0] rem_a;
  logic       busy_b, done_b, tick_b;
  logic [7:0] rem_b;

  phase_countdown_timer #(.CLK_FREQ(10), .SEC_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .dur_sec(dur_sec), .periodic(periodic),
    .pause(pause), .abort(abort), .busy(busy_a), .done(done_a), .tick(tick_a),
    .remaining(rem_a)
  );

  phase_countdown_timer #(.CLK_FREQ(1), .SEC_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .dur_sec(dur_sec), .periodic(periodic),
    .pause(pause), .abort(abort), .busy(busy_b), .done(done_b), .tick(tick_b),
    .remaining(rem_b)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  // Reference model per instance: active flag, duration, mode, and the
  // counted (non-paused) cycles elapsed in the current period.
  int m_act[2];
  int m_d[2];
  int m_per[2];
  int m_cnt[2];
  int m_done[2];
  int m_tick[2];

  int done_cnt_a  = 0;
  int last_done_a = 0;
  int done_cnt_b  = 0;
  int last_done_b = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input int k, input int f);
    m_done[k] = 0;
    m_tick[k] = 0;
    if (rst) begin
      m_act[k] = 0; m_cnt[k] = 0; m_per[k] = 0; m_d[k] = 0;
    end else if (abort) begin
      m_act[k] = 0; m_cnt[k] = 0;
    end else if (start) begin
      if (dur_sec == 8'd0) begin
        m_act[k] = 0; m_cnt[k] = 0; m_done[k] = 1;
      end else begin
        m_act[k] = 1; m_d[k] = int'(dur_sec); m_per[k] = int'(periodic); m_cnt[k] = 0;
      end
    end else if (m_act[k] != 0 && !pause) begin
      m_cnt[k]++;
      if (m_cnt[k] % f == 0) m_tick[k] = 1;
      if (m_cnt[k] == m_d[k] * f) begin
        m_done[k] = 1;
        m_cnt[k]  = 0;
        if (m_per[k] == 0) m_act[k] = 0;
      end
    end
  endtask

  function automatic int exp_rem(input int k, input int f);
    return (m_act[k] != 0) ? (m_d[k] - m_cnt[k] / f) : 0;
  endfunction

  task automatic step(input logic s, input logic [7:0] d, input logic p,
                      input logic pa, input logic ab, input logic r);
    start = s; dur_sec = d; periodic = p; pause = pa; abort = ab; rst = r;
    @(posedge clk);
    cyc++;
    model_edge(0, 10);
    model_edge(1, 1);
    #1;
    chk("a_busy", busy_a, m_act[0]);
    chk("a_done", done_a, m_done[0]);
    chk("a_tick", tick_a, m_tick[0]);
    chk("a_remaining", rem_a, exp_rem(0, 10));
    chk("b_busy", busy_b, m_act[1]);
    chk("b_done", done_b, m_done[1]);
    chk("b_tick", tick_b, m_tick[1]);
    chk("b_remaining", rem_b, exp_rem(1, 1));
    if (done_a === 1'b1) begin done_cnt_a++; last_done_a = cyc; end
    if (done_b === 1'b1) begin done_cnt_b++; last_done_b = cyc; end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    done_cnt_a = 0; last_done_a = 0; done_cnt_b = 0; last_done_b = 0;
  endtask

  initial begin
    int s0;
    int s1;
    logic       r_s, r_st, r_ab, r_pa, r_p;
    logic [7:0] r_d;
    int         sel;

    // Reset state.
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_busy", busy_a, 0);
    chk("reset_remaining", rem_a, 0);

    // One-shot 4 s.
    clear_counts();
    step(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    s0 = cyc;
    chk("t1_busy_after_start", busy_a, 1);
    chk("t1_remaining_after_start", rem_a, 4);
    idle(45);
    chk("t1_latency_a", last_done_a - s0, 40);
    chk("t1_latency_b", last_done_b - s0, 4);
    chk("t1_done_count_a", done_cnt_a, 1);

    // Periodic 3 s for 100 cycles.
    clear_counts();
    step(1'b1, 8'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    s0 = cyc;
    idle(100);
    chk("t2_done_count_a", done_cnt_a, 3);
    chk("t2_last_done_a", last_done_a - s0, 90);
    chk("t2_done_count_b", done_cnt_b, 33);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 25 s with a 17-cycle pause at cycle 55.
    clear_counts();
    step(1'b1, 8'd25, 1'b0, 1'b0, 1'b0, 1'b0);
    s0 = cyc;
    idle(55);
    chk("t3_remaining_before_pause", rem_a, 20);
    for (int i = 0; i < 17; i++) step(1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_remaining_frozen", rem_a, 20);
    chk("t3_busy_paused", busy_a, 1);
    idle(200);
    chk("t3_latency_a", last_done_a - s0, 267);
    chk("t3_done_count_a", done_cnt_a, 1);

    // Abort together with start at cycle 49.
    clear_counts();
    step(1'b1, 8'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(48);
    step(1'b1, 8'd5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_busy_after_abort", busy_a, 0);
    chk("t4_remaining_after_abort", rem_a, 0);
    idle(60);
    chk("t4_no_done_a", done_cnt_a, 0);

    // Abort on the exact expiry edge.
    clear_counts();
    step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(19);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(5);
    chk("t4_abort_expiry_no_done", done_cnt_a, 0);

    // Retrigger at cycle 15 of a 4 s count with 2 s.
    step(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(14);
    clear_counts();
    step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    s1 = cyc;
    idle(40);
    chk("t5_retrigger_done_count", done_cnt_a, 1);
    chk("t5_retrigger_latency", last_done_a - s1, 20);

    // Zero duration with periodic set: a single done, never busy.
    clear_counts();
    step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_zero_done", done_a, 1);
    chk("t5_zero_busy", busy_a, 0);
    idle(12);
    chk("t5_zero_done_count", done_cnt_a, 1);

    // Reset mid-run, on the edge where done would fire.
    step(1'b1, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(39);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_reset_done", done_a, 0);
    chk("t6_reset_tick", tick_a, 0);
    chk("t6_reset_busy", busy_a, 0);

    // Maximum duration, 255 s (CLK_FREQ=1 instance finishes).
    clear_counts();
    step(1'b1, 8'd255, 1'b0, 1'b0, 1'b0, 1'b0);
    s0 = cyc;
    chk("max_remaining", rem_a, 255);
    idle(260);
    chk("max_latency_b", last_done_b - s0, 255);
    step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      r_s  = ($urandom_range(0, 199) == 0);
      r_st = ($urandom_range(0, 39) == 0);
      r_ab = ($urandom_range(0, 79) == 0);
      r_pa = ($urandom_range(0, 5) == 0);
      r_p  = 1'($urandom_range(0, 1));
      sel  = int'($urandom_range(0, 9));
      if (sel == 0)      r_d = 8'd0;
      else if (sel == 1) r_d = 8'd255;
      else               r_d = 8'($urandom_range(1, 6));
      step(r_st, r_d, r_p, r_pa, r_ab, r_s);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
